// File: rtl/uart_line_arbiter.sv
// Request/grant arbiter sharing the single UART tx line between the command and data serializers.
// Round-robin on ties, idle-mark guard between owners, forced reclaim of over-long grants.
module uart_line_arbiter #(
  parameter int GUARD_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic req_cmd,
  input  logic done_cmd,
  input  logic tx_cmd,
  input  logic req_dat,
  input  logic done_dat,
  input  logic tx_dat,
  output logic gnt_cmd,
  output logic gnt_dat,
  output logic tx,
  output logic busy,
  output logic timeout_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_CMD = 2'd1,
    GRANT_DAT = 2'd2,
    GUARD     = 2'd3
  } state_t;

  localparam logic OWNER_CMD = 1'b0;
  localparam logic OWNER_DAT = 1'b1;

  // Last count of a grant / guard interval; GUARD_LAST is unused when the guard is disabled.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'(GUARD_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_owner;

  logic own_done;
  logic own_req;
  logic own_expired;
  logic release_now;
  logic pick_dat;

  // Only the current owner's handshake matters; the other source is masked out here.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    own_done = 1'b0;
    own_req  = 1'b0;
    case (state)
      GRANT_CMD: begin
        own_done = done_cmd;
        own_req  = req_cmd;
      end
      GRANT_DAT: begin
        own_done = done_dat;
        own_req  = req_dat;
      end
      default: begin
        own_done = 1'b0;
        own_req  = 1'b0;
      end
    endcase
  end

  assign own_expired = (cnt == TIMEOUT_LAST);
  assign release_now = own_done || !own_req || own_expired;

  // Tie goes to whichever source did not own the line last.
  assign pick_dat = req_dat && (!req_cmd || (last_owner == OWNER_CMD));

  // NOTE: sequential state uses non-blocking assignments only; all outputs are registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      last_owner  <= OWNER_DAT;
      gnt_cmd     <= 1'b0;
      gnt_dat     <= 1'b0;
      tx          <= 1'b1;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          tx  <= 1'b1;
          cnt <= '0;
          if (req_cmd || req_dat) begin
            state   <= pick_dat ? GRANT_DAT : GRANT_CMD;
            gnt_cmd <= !pick_dat;
            gnt_dat <= pick_dat;
            busy    <= 1'b1;
          end
        end

        GRANT_CMD, GRANT_DAT: begin
          tx <= (state == GRANT_CMD) ? tx_cmd : tx_dat;
          if (release_now) begin
            last_owner  <= (state == GRANT_DAT) ? OWNER_DAT : OWNER_CMD;
            gnt_cmd     <= 1'b0;
            gnt_dat     <= 1'b0;
            cnt         <= '0;
            // A coincident done or request drop counts as a normal completion.
            timeout_err <= own_expired && !own_done && own_req;
            if (GUARD_CYCLES == 0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= GUARD;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        GUARD: begin
          tx <= 1'b1;
          if (cnt == GUARD_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_line_arbiter.sv
// Directed bench for uart_line_arbiter: reset, framing, round-robin, timeout,
// non-owner interference and reset mid-frame, with GUARD_CYCLES=4, TIMEOUT_CYCLES=32.
module tb_uart_line_arbiter;

  localparam int GUARD = 4;
  localparam int TMO   = 32;

  logic clk = 1'b0;
  logic rst;
  logic req_cmd, done_cmd, tx_cmd;
  logic req_dat, done_dat, tx_dat;
  logic gnt_cmd, gnt_dat, tx, busy, timeout_err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [9:0] frame  = 10'b1011001010;
  logic [5:0] pat    = 6'b101100;
  logic [9:0] dframe = 10'b0110100110;

  uart_line_arbiter #(
    .GUARD_CYCLES  (GUARD),
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_cmd    (req_cmd),
    .done_cmd   (done_cmd),
    .tx_cmd     (tx_cmd),
    .req_dat    (req_dat),
    .done_dat   (done_dat),
    .tx_dat     (tx_dat),
    .gnt_cmd    (gnt_cmd),
    .gnt_dat    (gnt_dat),
    .tx         (tx),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the edge; grants must never overlap.
  task automatic tick();
    @(posedge clk);
    #1;
    check("gnt_mutex", gnt_cmd & gnt_dat, 1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    req_cmd  = 1'b0;
    done_cmd = 1'b0;
    tx_cmd   = 1'b1;
    req_dat  = 1'b0;
    done_dat = 1'b0;
    tx_dat   = 1'b1;
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_gnt_cmd", gnt_cmd, 1'b0);
    check("rst_gnt_dat", gnt_dat, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_timeout", timeout_err, 1'b0);

    // Reset held while the sources toggle everything.
    for (int i = 0; i < 6; i++) begin
      req_cmd  = i[0];
      req_dat  = ~i[0];
      tx_cmd   = i[1];
      tx_dat   = ~i[1];
      done_cmd = i[0];
      done_dat = i[1];
      tick();
      check("rst_hold_tx", tx, 1'b1);
      check("rst_hold_gnt_cmd", gnt_cmd, 1'b0);
      check("rst_hold_gnt_dat", gnt_dat, 1'b0);
      check("rst_hold_busy", busy, 1'b0);
    end
    req_cmd  = 1'b0;
    req_dat  = 1'b0;
    done_cmd = 1'b0;
    done_dat = 1'b0;
    tx_cmd   = 1'b1;
    tx_dat   = 1'b1;
    rst      = 1'b0;
    tick();
    check("idle_busy", busy, 1'b0);
    check("idle_gnt_cmd", gnt_cmd, 1'b0);
    check("idle_tx", tx, 1'b1);

    // Single command frame.
    req_cmd = 1'b1;
    tick();
    check("cmd_gnt", gnt_cmd, 1'b1);
    check("cmd_gnt_dat", gnt_dat, 1'b0);
    check("cmd_busy", busy, 1'b1);
    check("cmd_tx_pre", tx, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tx_cmd = frame[i];
      tick();
      check("cmd_frame_tx", tx, frame[i]);
      check("cmd_frame_gnt", gnt_cmd, 1'b1);
    end
    done_cmd = 1'b1;
    tx_cmd   = 1'b1;
    tick();
    check("cmd_rel_gnt", gnt_cmd, 1'b0);
    check("cmd_rel_busy", busy, 1'b1);
    check("cmd_rel_timeout", timeout_err, 1'b0);
    done_cmd = 1'b0;
    req_cmd  = 1'b0;
    for (int i = 0; i < GUARD - 1; i++) begin
      tick();
      check("cmd_guard_tx", tx, 1'b1);
      check("cmd_guard_busy", busy, 1'b1);
      check("cmd_guard_gnt", gnt_cmd, 1'b0);
    end
    tick();
    check("cmd_back_idle", busy, 1'b0);

    // Simultaneous requests after a fresh reset: cmd, dat, cmd, dat.
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    req_cmd = 1'b1;
    req_dat = 1'b1;
    tick();
    check("tie_first_cmd", gnt_cmd, 1'b1);
    check("tie_first_dat", gnt_dat, 1'b0);
    for (int r = 0; r < 3; r++) begin
      done_cmd = (r % 2 == 0);
      done_dat = (r % 2 == 1);
      tick();
      check("rr_rel_cmd", gnt_cmd, 1'b0);
      check("rr_rel_dat", gnt_dat, 1'b0);
      check("rr_rel_timeout", timeout_err, 1'b0);
      done_cmd = 1'b0;
      done_dat = 1'b0;
      for (int g = 0; g < GUARD; g++) begin
        tick();
        check("rr_guard_cmd", gnt_cmd, 1'b0);
        check("rr_guard_dat", gnt_dat, 1'b0);
      end
      tick();
      check("rr_next_cmd", gnt_cmd, (r % 2 == 1));
      check("rr_next_dat", gnt_dat, (r % 2 == 0));
    end

    // Dat owns the line; cmd withdraws, dat asks again back to back.
    done_dat = 1'b1;
    req_cmd  = 1'b0;
    tick();
    check("b2b_rel_dat", gnt_dat, 1'b0);
    done_dat = 1'b0;
    for (int g = 0; g < GUARD; g++) begin
      tick();
      check("b2b_guard_dat", gnt_dat, 1'b0);
    end
    tick();
    check("b2b_regrant_dat", gnt_dat, 1'b1);

    // Timeout: dat never finishes, cmd becomes pending meanwhile.
    req_cmd = 1'b1;
    for (int k = 1; k < TMO; k++) begin
      tick();
      check("tmo_hold_gnt", gnt_dat, 1'b1);
      check("tmo_hold_err", timeout_err, 1'b0);
    end
    tick();
    check("tmo_drop_gnt", gnt_dat, 1'b0);
    check("tmo_err_pulse", timeout_err, 1'b1);
    tick();
    check("tmo_err_single", timeout_err, 1'b0);
    check("tmo_guard_busy", busy, 1'b1);
    for (int g = 0; g < GUARD - 2; g++) begin
      tick();
      check("tmo_guard_gnt_cmd", gnt_cmd, 1'b0);
      check("tmo_guard_gnt_dat", gnt_dat, 1'b0);
      check("tmo_guard_busy2", busy, 1'b1);
    end
    tick();
    check("tmo_idle_busy", busy, 1'b0);
    tick();
    check("tmo_next_cmd", gnt_cmd, 1'b1);
    check("tmo_next_dat", gnt_dat, 1'b0);

    // Non-owner interference during GRANT_CMD.
    for (int i = 0; i < 6; i++) begin
      tx_cmd   = pat[i];
      tx_dat   = ~pat[i];
      done_dat = (i == 2);
      tick();
      check("intf_tx", tx, pat[i]);
      check("intf_gnt_cmd", gnt_cmd, 1'b1);
      check("intf_gnt_dat", gnt_dat, 1'b0);
    end
    done_dat = 1'b0;
    tx_cmd   = 1'b1;
    tx_dat   = 1'b1;
    req_cmd  = 1'b0;
    tick();
    check("reqdrop_gnt_cmd", gnt_cmd, 1'b0);
    check("reqdrop_busy", busy, 1'b1);
    check("reqdrop_timeout", timeout_err, 1'b0);
    for (int g = 0; g < GUARD; g++) begin
      tick();
      check("reqdrop_guard_dat", gnt_dat, 1'b0);
    end
    tick();
    check("dat_after_cmd", gnt_dat, 1'b1);

    // Reset mid-frame at bit 5 of a data frame.
    req_cmd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tx_dat = dframe[i];
      tick();
      check("dframe_tx", tx, dframe[i]);
    end
    tx_dat = dframe[5];
    #2;
    rst = 1'b1;
    #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_gnt_dat", gnt_dat, 1'b0);
    check("midrst_gnt_cmd", gnt_cmd, 1'b0);
    check("midrst_busy", busy, 1'b0);
    tick();
    check("midrst_hold_tx", tx, 1'b1);
    check("midrst_hold_gnt", gnt_dat, 1'b0);
    rst = 1'b0;
    tick();
    check("postrst_cmd", gnt_cmd, 1'b1);
    check("postrst_dat", gnt_dat, 1'b0);
    req_cmd = 1'b0;
    req_dat = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
